// File: rtl/spi_seq_pkg.sv
// Shared types, constants and helpers for the SPI transfer sequencer.
package spi_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DUMMY  = 3'd3,
        ST_DATA   = 3'd4,
        ST_FINISH = 3'd5
    } state_e;

    localparam logic [15:0] CMD_BITS      = 16'd8;
    localparam logic [5:0]  ADDR_MAX_BITS = 6'd32;

    function automatic logic [5:0] addr_len_clamp(input logic [5:0] len);
        if (len > ADDR_MAX_BITS) begin
            return ADDR_MAX_BITS;
        end else begin
            return len;
        end
    endfunction

    // Quad reads move whole nibbles, so the two LSBs of the length are dropped.
    function automatic logic [15:0] rd_len_eff(input logic [15:0] len, input logic quad);
        if (quad) begin
            return {len[15:2], 2'b00};
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/spi_seq_cnt.sv
// Loadable down-counter advanced by SPI edge pulses; times the dummy phase.
module spi_seq_cnt
    import spi_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         zero,
    output logic         last
);

    logic [W-1:0] count_q, count_d;

    // Next count: load wins, otherwise decrement on enabled pulses without wrapping.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != {W{1'b0}})) begin
            count_d = count_q - W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == {W{1'b0}});
    assign last  = en && (count_q == W'(1));

endmodule

// File: rtl/spi_xfer_seq.sv
// SPI transaction sequencer: CMD -> ADDR -> DUMMY -> DATA with phase skipping,
// abort and registered outputs decoded from the next state.
module spi_xfer_seq
    import spi_seq_pkg::*;
#(
    parameter int DUMMY_W = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [7:0]         req_cmd,
    input  logic [31:0]        req_addr,
    input  logic [5:0]         req_addr_len,
    input  logic [DUMMY_W-1:0] req_dummy,
    input  logic [15:0]        req_rd_len,
    input  logic               req_quad,
    input  logic               abort,
    input  logic               spi_edge,
    output logic               cs_n,
    output logic               en_quad,
    output logic               tx_en,
    output logic               tx_counter_upd,
    output logic [15:0]        tx_counter,
    output logic [31:0]        tx_data,
    output logic               tx_data_valid,
    input  logic               tx_data_ready,
    input  logic               tx_done,
    output logic               rx_en,
    output logic               rx_counter_upd,
    output logic [15:0]        rx_counter,
    input  logic               rx_done,
    output logic               busy,
    output logic               done
);

    state_e state_q, state_d;

    logic [7:0]         cmd_q, cmd_d;
    logic [31:0]        addr_q, addr_d;
    logic [5:0]         alen_q, alen_d;
    logic [DUMMY_W-1:0] dummy_q, dummy_d;
    logic [15:0]        rdlen_q, rdlen_d;
    logic               quad_q, quad_d;

    logic        req_ready_q, req_ready_d;
    logic        cs_n_q, cs_n_d;
    logic        en_quad_q, en_quad_d;
    logic        tx_en_q, tx_en_d;
    logic        tx_upd_q, tx_upd_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [31:0] tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        rx_en_q, rx_en_d;
    logic        rx_upd_q, rx_upd_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic               accept_s;
    logic               entering_s;
    logic [5:0]         alen_c_s;
    logic [5:0]         addr_shift_s;
    logic [15:0]        rd_eff_s;
    state_e             after_cmd_s, after_addr_s, after_dummy_s;
    logic               cnt_load_s, cnt_en_s, cnt_zero_s, cnt_last_s;
    logic [DUMMY_W-1:0] cnt_val_s;

    assign accept_s     = (state_q == ST_IDLE) && req_ready_q && req_valid;
    assign alen_c_s     = addr_len_clamp(alen_d);
    assign addr_shift_s = ADDR_MAX_BITS - alen_c_s;
    assign rd_eff_s     = rd_len_eff(rdlen_d, quad_d);
    assign entering_s   = (state_d != state_q);

    // Phase-skip chain: each exit falls through to the next phase with a non-zero length.
    assign after_dummy_s = (rd_eff_s != 16'd0)              ? ST_DATA  : ST_FINISH;
    assign after_addr_s  = (dummy_d != {DUMMY_W{1'b0}})     ? ST_DUMMY : after_dummy_s;
    assign after_cmd_s   = (alen_c_s != 6'd0)               ? ST_ADDR  : after_addr_s;

    assign cnt_load_s = (state_d == ST_DUMMY) && (state_q != ST_DUMMY);
    assign cnt_en_s   = spi_edge && (state_q == ST_DUMMY);

    spi_seq_cnt #(.W(DUMMY_W)) u_dummy_cnt (
        .clk      (clk),
        .rstn     (rstn),
        .load     (cnt_load_s),
        .load_val (dummy_d),
        .en       (cnt_en_s),
        .count    (cnt_val_s),
        .zero     (cnt_zero_s),
        .last     (cnt_last_s)
    );

    // Request capture: fields are frozen from acceptance until the next acceptance.
    always_comb begin
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        alen_d  = alen_q;
        dummy_d = dummy_q;
        rdlen_d = rdlen_q;
        quad_d  = quad_q;
        if (accept_s) begin
            cmd_d   = req_cmd;
            addr_d  = req_addr;
            alen_d  = req_addr_len;
            dummy_d = req_dummy;
            rdlen_d = req_rd_len;
            quad_d  = req_quad;
        end else begin
            cmd_d   = cmd_q;
        end
    end

    // Next-state logic; abort takes priority over any phase-done input.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) state_d = ST_CMD;
                else          state_d = ST_IDLE;
            end
            ST_CMD: begin
                if (abort)        state_d = ST_FINISH;
                else if (tx_done) state_d = after_cmd_s;
                else              state_d = ST_CMD;
            end
            ST_ADDR: begin
                if (abort)        state_d = ST_FINISH;
                else if (tx_done) state_d = after_addr_s;
                else              state_d = ST_ADDR;
            end
            ST_DUMMY: begin
                // The zero guard keeps a corrupted count from stalling the bus.
                if (abort)                         state_d = ST_FINISH;
                else if (cnt_last_s || cnt_zero_s) state_d = after_dummy_s;
                else                               state_d = ST_DUMMY;
            end
            ST_DATA: begin
                if (abort)        state_d = ST_FINISH;
                else if (rx_done) state_d = ST_FINISH;
                else              state_d = ST_DATA;
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        req_ready_d = 1'b0;
        cs_n_d      = 1'b1;
        en_quad_d   = 1'b0;
        tx_en_d     = 1'b0;
        tx_upd_d    = 1'b0;
        tx_cnt_d    = 16'd0;
        tx_data_d   = 32'd0;
        tx_valid_d  = 1'b0;
        rx_en_d     = 1'b0;
        rx_upd_d    = 1'b0;
        rx_cnt_d    = 16'd0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        case (state_d)
            ST_IDLE: begin
                req_ready_d = 1'b1;
            end
            ST_CMD: begin
                cs_n_d     = 1'b0;
                busy_d     = 1'b1;
                tx_en_d    = 1'b1;
                tx_upd_d   = entering_s;
                tx_cnt_d   = CMD_BITS;
                tx_data_d  = {cmd_d, 24'h000000};
                tx_valid_d = entering_s || (tx_valid_q && !tx_data_ready);
            end
            ST_ADDR: begin
                cs_n_d     = 1'b0;
                busy_d     = 1'b1;
                tx_en_d    = 1'b1;
                en_quad_d  = quad_d;
                tx_upd_d   = entering_s;
                tx_cnt_d   = {10'd0, alen_c_s};
                tx_data_d  = addr_d << addr_shift_s;
                tx_valid_d = entering_s || (tx_valid_q && !tx_data_ready);
            end
            ST_DUMMY: begin
                cs_n_d = 1'b0;
                busy_d = 1'b1;
            end
            ST_DATA: begin
                cs_n_d    = 1'b0;
                busy_d    = 1'b1;
                rx_en_d   = 1'b1;
                en_quad_d = quad_d;
                rx_upd_d  = entering_s;
                rx_cnt_d  = rd_eff_s;
            end
            ST_FINISH: begin
                done_d = 1'b1;
            end
            default: begin
                cs_n_d = 1'b1;
            end
        endcase
    end

    // State, captured request and output registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cmd_q       <= 8'd0;
            addr_q      <= 32'd0;
            alen_q      <= 6'd0;
            dummy_q     <= {DUMMY_W{1'b0}};
            rdlen_q     <= 16'd0;
            quad_q      <= 1'b0;
            req_ready_q <= 1'b0;
            cs_n_q      <= 1'b1;
            en_quad_q   <= 1'b0;
            tx_en_q     <= 1'b0;
            tx_upd_q    <= 1'b0;
            tx_cnt_q    <= 16'd0;
            tx_data_q   <= 32'd0;
            tx_valid_q  <= 1'b0;
            rx_en_q     <= 1'b0;
            rx_upd_q    <= 1'b0;
            rx_cnt_q    <= 16'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            alen_q      <= alen_d;
            dummy_q     <= dummy_d;
            rdlen_q     <= rdlen_d;
            quad_q      <= quad_d;
            req_ready_q <= req_ready_d;
            cs_n_q      <= cs_n_d;
            en_quad_q   <= en_quad_d;
            tx_en_q     <= tx_en_d;
            tx_upd_q    <= tx_upd_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            rx_en_q     <= rx_en_d;
            rx_upd_q    <= rx_upd_d;
            rx_cnt_q    <= rx_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign cs_n           = cs_n_q;
    assign en_quad        = en_quad_q;
    assign tx_en          = tx_en_q;
    assign tx_counter_upd = tx_upd_q;
    assign tx_counter     = tx_cnt_q;
    assign tx_data        = tx_data_q;
    assign tx_data_valid  = tx_valid_q;
    assign rx_en          = rx_en_q;
    assign rx_counter_upd = rx_upd_q;
    assign rx_counter     = rx_cnt_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Bench for spi_xfer_seq: scripted handshakes against a phase-plan model of each request.
module tb_spi_xfer_seq;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          req_valid, req_ready;
    logic [7:0]    req_cmd;
    logic [31:0]   req_addr;
    logic [5:0]    req_addr_len;
    logic [DW-1:0] req_dummy;
    logic [15:0]   req_rd_len;
    logic          req_quad, abort, spi_edge;
    logic          cs_n, en_quad, tx_en, tx_counter_upd, tx_data_valid;
    logic [15:0]   tx_counter, rx_counter;
    logic [31:0]   tx_data;
    logic          tx_data_ready, tx_done, rx_en, rx_counter_upd, rx_done, busy, done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spi_xfer_seq #(.DUMMY_W(DW)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_addr(req_addr), .req_addr_len(req_addr_len),
        .req_dummy(req_dummy), .req_rd_len(req_rd_len), .req_quad(req_quad),
        .abort(abort), .spi_edge(spi_edge), .cs_n(cs_n), .en_quad(en_quad),
        .tx_en(tx_en), .tx_counter_upd(tx_counter_upd), .tx_counter(tx_counter),
        .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready),
        .tx_done(tx_done), .rx_en(rx_en), .rx_counter_upd(rx_counter_upd),
        .rx_counter(rx_counter), .rx_done(rx_done), .busy(busy), .done(done)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid = 1'b0; abort = 1'b0; spi_edge = 1'b0;
        tx_data_ready = 1'b0; tx_done = 1'b0; rx_done = 1'b0;
    endtask

    task automatic scramble_req();
        req_cmd = 8'($urandom); req_addr = $urandom; req_addr_len = 6'($urandom);
        req_dummy = DW'($urandom); req_rd_len = 16'($urandom); req_quad = 1'($urandom);
    endtask

    task automatic chk_reset(input string tag);
        chk_eq({tag, "_cs_n"}, cs_n, 1);
        chk_eq({tag, "_outs"}, {req_ready, busy, done, tx_en, rx_en, tx_counter_upd,
                                rx_counter_upd, tx_data_valid, en_quad}, 0);
        chk_eq({tag, "_txcnt"}, tx_counter, 0);
        chk_eq({tag, "_rxcnt"}, rx_counter, 0);
        chk_eq({tag, "_txdata"}, tx_data, 0);
    endtask

    task automatic chk_idle(input string tag);
        chk_eq({tag, "_ready"}, req_ready, 1);
        chk_eq({tag, "_cs_n"}, cs_n, 1);
        chk_eq({tag, "_busy_done"}, {busy, done}, 0);
        chk_eq({tag, "_en"}, {tx_en, rx_en, tx_data_valid}, 0);
    endtask

    task automatic chk_finish(input string tag);
        chk_eq({tag, "_cs_n"}, cs_n, 1);
        chk_eq({tag, "_done"}, done, 1);
        chk_eq({tag, "_busy_ready"}, {busy, req_ready}, 0);
        chk_eq({tag, "_en"}, {tx_en, rx_en, tx_data_valid}, 0);
    endtask

    // Phases: 1=CMD 2=ADDR 3=DUMMY 4=DATA. kill_ph selects a phase in which to abort
    // (or pull reset when kill_rst) at cycle kill_cyc of that phase; 0 means none.
    task automatic run_xfer(input logic [7:0] cmd, input logic [31:0] addr,
                            input logic [5:0] alen, input logic [DW-1:0] dum,
                            input logic [15:0] rdl, input logic quad, input int rdy_dly,
                            input int kill_ph, input int kill_cyc, input bit kill_rst);
        int          alen_c;
        logic [63:0] wide;
        logic [31:0] exp_ad;
        logic [15:0] rd_eff;
        int          ph[$];
        bit          ended;
        int          r, dn, edges, c;
        bit          last_cyc, kill_here;

        alen_c = (int'(alen) > 32) ? 32 : int'(alen);
        wide   = {32'h0, addr} << (32 - alen_c);
        exp_ad = wide[31:0];
        rd_eff = quad ? (rdl & 16'hFFFC) : rdl;
        ph.push_back(1);
        if (alen_c > 0)      ph.push_back(2);
        if (dum != 0)        ph.push_back(3);
        if (rd_eff != 16'd0) ph.push_back(4);

        chk_eq("req_ready_before", req_ready, 1);
        req_valid = 1'b1; req_cmd = cmd; req_addr = addr; req_addr_len = alen;
        req_dummy = dum; req_rd_len = rdl; req_quad = quad;
        step();
        ended = 1'b0;
        for (int i = 0; i < ph.size() && !ended; i++) begin
            kill_here = (kill_ph == ph[i]);
            r  = (ph[i] == 1) ? rdy_dly : $urandom_range(0, 3);
            dn = (ph[i] == 4) ? $urandom_range(0, 4) : r + $urandom_range(0, 3);
            if (kill_here && dn < kill_cyc) dn = kill_cyc;
            edges = 0;
            c     = 0;
            while (!ended) begin
                chk_eq("xfer_cs_busy", {cs_n, busy, req_ready, done}, 4'b0100);
                req_valid = 1'($urandom);
                scramble_req();
                abort = 1'b0;
                last_cyc = 1'b0;
                case (ph[i])
                    1, 2: begin
                        chk_eq("tx_en", {tx_en, rx_en, rx_counter_upd}, 3'b100);
                        chk_eq("tx_upd", tx_counter_upd, (c == 0));
                        chk_eq("tx_valid", tx_data_valid, (c <= r));
                        chk_eq("tx_en_quad", en_quad, (ph[i] == 2) ? quad : 1'b0);
                        chk_eq("tx_counter", tx_counter, (ph[i] == 1) ? 8 : alen_c);
                        chk_eq("tx_data", tx_data, (ph[i] == 1) ? {cmd, 24'h0} : exp_ad);
                        tx_data_ready = (c == r) ? 1'b1 : ((c < r) ? 1'b0 : 1'($urandom));
                        tx_done  = (c == dn);
                        rx_done  = 1'($urandom);
                        spi_edge = 1'($urandom);
                        last_cyc = (c == dn);
                    end
                    3: begin
                        chk_eq("dummy_en", {tx_en, rx_en, tx_data_valid, tx_counter_upd,
                                            rx_counter_upd}, 0);
                        if (kill_here) spi_edge = (c >= kill_cyc);
                        else           spi_edge = (c >= 50) ? 1'b1 : 1'($urandom);
                        tx_done  = 1'($urandom);
                        rx_done  = 1'($urandom);
                        last_cyc = spi_edge && (edges + 1 == int'(dum));
                        edges    = edges + int'(spi_edge);
                    end
                    default: begin
                        chk_eq("rx_en", {rx_en, tx_en, tx_data_valid, tx_counter_upd}, 4'b1000);
                        chk_eq("rx_upd", rx_counter_upd, (c == 0));
                        chk_eq("rx_en_quad", en_quad, quad);
                        chk_eq("rx_counter", rx_counter, rd_eff);
                        rx_done  = (c == dn);
                        tx_done  = 1'($urandom);
                        tx_data_ready = 1'($urandom);
                        spi_edge = 1'($urandom);
                        last_cyc = (c == dn);
                    end
                endcase
                if (kill_here && c == kill_cyc) begin
                    if (kill_rst) begin
                        rstn = 1'b0;
                        step();
                        chk_reset("rst_mid");
                        rstn = 1'b1;
                        clear_inputs();
                        step();
                        chk_eq("rdy_after_rst", req_ready, 1);
                        chk_eq("no_done_after_rst", done, 0);
                    end else begin
                        abort = 1'b1;
                        step();
                        clear_inputs();
                        chk_finish("abort_fin");
                        step();
                        chk_idle("abort_idle_after");
                    end
                    ended = 1'b1;
                end else begin
                    step();
                    c++;
                    if (last_cyc) break;
                end
            end
        end
        if (!ended) begin
            clear_inputs();
            chk_finish("fin");
            step();
            chk_idle("idle_after");
        end
    endtask

    initial begin
        rstn = 1'b0;
        clear_inputs();
        scramble_req();
        step();
        step();
        chk_reset("por");
        rstn = 1'b1;
        step();
        chk_idle("idle_first");

        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_idle("abort_in_idle");

        run_xfer(8'hEB, 32'h123456, 6'd24, DW'(4), 16'd32, 1'b1, 0, 0, 0, 1'b0);
        run_xfer(8'h03, 32'hDEAD, 6'd0, DW'(0), 16'd16, 1'b0, 1, 0, 0, 1'b0);
        run_xfer(8'hEB, 32'h0, 6'd0, DW'(0), 16'd8, 1'b0, 5, 0, 0, 1'b0);
        run_xfer(8'h6B, 32'hABC, 6'd16, DW'(2), 16'd64, 1'b1, 0, 4, 2, 1'b0);
        run_xfer(8'h0B, 32'h55AA, 6'd24, DW'(3), 16'd32, 1'b0, 0, 2, 1, 1'b1);
        run_xfer(8'hBB, 32'h1, 6'd0, DW'(0), 16'd13, 1'b1, 0, 0, 0, 1'b0);
        run_xfer(8'hBB, 32'h1, 6'd0, DW'(0), 16'd3, 1'b1, 0, 0, 0, 1'b0);
        run_xfer(8'h9F, 32'h89ABCDEF, 6'd40, DW'(1), 16'd1, 1'b0, 2, 0, 0, 1'b0);
        run_xfer(8'h05, 32'h7, 6'd3, DW'(0), 16'd0, 1'b0, 0, 0, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            int kp;
            kp = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 4) : 0;
            run_xfer(8'($urandom), $urandom,
                     ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 40)),
                     DW'($urandom_range(0, 5)),
                     ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3))
                                                 : 16'($urandom_range(1, 300)),
                     1'($urandom), $urandom_range(0, 3), kp, $urandom_range(0, 2),
                     ($urandom_range(0, 2) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_xfer_seq.md
SPI_XFER_SEQ -- requirements
Module: spi_xfer_seq

Interface
REQ-001 Parameter: DUMMY_W, default 8, width of dummy-cycle count.
REQ-002 clk  in  1  single block clock.
REQ-003 rstn  in  1  reset, synchronous, active-low.
REQ-004 req_valid  in  1  transaction request.
REQ-005 req_ready  out  1  sequencer idle and able to accept a request.
REQ-006 req_cmd  in  8  command byte, always sent single-lane.
REQ-007 req_addr  in  32  address, right-aligned.
REQ-008 req_addr_len  in  6  address bits, 0..32.
REQ-009 req_dummy  in  DUMMY_W  dummy SPI clock cycles.
REQ-010 req_rd_len  in  16  read bits.
REQ-011 req_quad  in  1  quad lanes for address and data phases.
REQ-012 abort  in  1  terminate the current transaction.
REQ-013 spi_edge  in  1  one-cycle pulse per SPI clock period.
REQ-014 cs_n  out  1  chip select, active-low.
REQ-015 en_quad  out  1  lane mode to TX/RX datapaths.
REQ-016 tx_en, tx_counter_upd  out  1 each  TX enable, TX bit-count load pulse.
REQ-017 tx_counter  out  16  TX bit count.
REQ-018 tx_data  out  32  TX word, MSB-first.
REQ-019 tx_data_valid  out  1  TX word valid.
REQ-020 tx_data_ready, tx_done  in  1 each  TX word accepted, TX phase complete.
REQ-021 rx_en, rx_counter_upd  out  1 each  RX enable, RX bit-count load pulse.
REQ-022 rx_counter  out  16  RX bit count.
REQ-023 rx_done  in  1  RX phase complete.
REQ-024 busy, done  out  1 each  transaction in progress, one-cycle completion pulse.

Function
REQ-025 The FSM SHALL have states IDLE, CMD, ADDR, DUMMY, DATA, FINISH; req_ready=1 and cs_n=1 only in IDLE.
REQ-026 In IDLE, req_valid&req_ready SHALL capture all req_* fields and enter CMD next cycle with cs_n=0 and busy=1; req_valid outside IDLE SHALL be ignored.
REQ-027 On entry to CMD, ADDR or DATA, the matching *_counter_upd SHALL pulse for exactly the first state cycle, with the counter holding the phase bit count.
REQ-028 CMD: tx_en=1, en_quad=0, tx_counter=8, tx_data={cmd,24'h0}; tx_data_valid SHALL be held from entry until the cycle tx_data_ready=1, then deasserted.
REQ-029 ADDR: tx_en=1, en_quad=req_quad, tx_counter=min(addr_len,32), tx_data=addr shifted left by (32-len); same valid/ready rule as REQ-028.
REQ-030 DUMMY: tx_en=rx_en=0, cs_n=0; an internal counter SHALL count spi_edge pulses and leave on the req_dummy-th pulse.
REQ-031 DATA: rx_en=1, en_quad=req_quad, rx_counter=rd_len, with rd_len[1:0] forced to 0 when req_quad=1; leave on rx_done.
REQ-032 Phase skipping: each phase exit, and entry from CMD, SHALL go to the next phase whose length is non-zero (ADDR, DUMMY, DATA, in that order), otherwise to FINISH.
REQ-033 A phase SHALL complete only on tx_done (CMD/ADDR), the terminal spi_edge (DUMMY) or rx_done (DATA); done inputs arriving in other states SHALL be ignored.
REQ-034 FINISH SHALL last one cycle: cs_n=1, done=1, busy=0; IDLE follows, and a new request is accepted no earlier than the cycle after FINISH.
REQ-035 abort=1 in any state other than IDLE or FINISH SHALL enter FINISH next cycle, deasserting tx_en, rx_en and tx_data_valid in that same edge; abort in IDLE SHALL be ignored.
REQ-036 If abort and a phase-done input occur together, abort SHALL win.
REQ-037 Captured request fields SHALL remain stable from capture until FINISH.

Reset
REQ-038 While rstn=0 at a clk edge: state IDLE; cs_n=1; all other outputs 0, including req_ready; captured fields and dummy counter 0.
REQ-039 req_ready SHALL be 1 in the first cycle after rstn returns high.
REQ-040 Reset asserted mid-transaction SHALL abandon it with no done pulse.

Structure
REQ-041 Package spi_seq_pkg SHALL hold the state enum typedef, the CMD_BITS=8 constant and the address-length limit 32.
REQ-042 The dummy counter SHALL be the sub-module spi_seq_cnt (loadable down-counter, spi_edge-enabled, zero flag).

Verification
REQ-043 Request cmd=0xEB, addr=0x123456, addr_len=24, dummy=4, rd_len=32, quad=1 -> upd pulses with tx_counter 8 then 24, four spi_edge pulses in DUMMY, rx_counter=32, en_quad 0/1/1, one done pulse.
REQ-044 addr_len=0, dummy=0, rd_len=16 -> CMD goes directly to DATA; no ADDR or DUMMY cycles.
REQ-045 tx_data_ready held low 5 cycles in CMD -> tx_data_valid stays 1 with tx_data=0xEB000000 throughout.
REQ-046 abort in the third DATA cycle -> FINISH next cycle, rx_en=0, cs_n=1, done=1.
REQ-047 rstn=0 during ADDR -> all outputs at reset values next edge, no done, req_ready=1 after release.
REQ-048 quad=1, rd_len=13 -> rx_counter=12; with rd_len=3 the DATA phase is skipped.
